// File: rtl/md_unit.sv
// md_unit: multiply/divide sequencer for the EX stage.
// Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO and owns the HI/LO registers.
// The multi-cycle latency is modelled by a busy down-counter. The result is
// computed when the op is accepted, held in hi_pend/lo_pend, and committed
// on the edge where the counter expires.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - EX instruction is an md op; qualifies md_op/A/B
//   md_op       - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   A, B        - rs / rt operands
//   id_uses_md  - ID instruction depends on HI/LO or the md unit
//   busy        - multi-cycle operation in progress (registered)
//   HI, LO      - architectural HI/LO registers (registered)
//   md_stall    - combinational stall request to pipeline control
//
// state  | meaning
// S_IDLE | accepts start; MTHI/MTLO write HI/LO directly
// S_RUN  | counting down; start ignored; HI/LO frozen
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        id_uses_md,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        md_stall
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [31:0] hi_pend, lo_pend;
  logic        div_zero;

  logic        is_md_op;
  logic        b_zero;
  logic [3:0]  cnt_load;
  logic [63:0] prod_s, prod_u;
  logic [31:0] div_b;
  logic [31:0] a_mag, b_mag, qs_mag, rs_mag;
  logic [31:0] res_hi, res_lo;

  assign is_md_op = ~md_op[2];
  assign b_zero   = (B == 32'd0);
  assign cnt_load = md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

  // Low 64 bits of the product of the sign-extended operands equal the
  // two's-complement signed product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Divisor forced non-zero so the dividers never see /0; the result is
  // discarded at commit in that case anyway.
  assign div_b  = b_zero ? 32'd1 : B;

  // Signed divide on magnitudes. 0x80000000 / -1 falls out naturally:
  // magnitude 0x80000000, no negation, remainder 0.
  assign a_mag  = A[31] ? (32'd0 - A) : A;
  assign b_mag  = div_b[31] ? (32'd0 - div_b) : div_b;
  assign qs_mag = a_mag / b_mag;
  assign rs_mag = a_mag % b_mag;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md_op)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        res_lo = (A[31] ^ div_b[31]) ? (32'd0 - qs_mag) : qs_mag;
        res_hi = A[31] ? (32'd0 - rs_mag) : rs_mag;
      end
      OP_DIVU: begin
        res_lo = A / div_b;
        res_hi = A % div_b;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      HI       <= 32'd0;
      LO       <= 32'd0;
      hi_pend  <= 32'd0;
      lo_pend  <= 32'd0;
      div_zero <= 1'b0;
    end else if (state == S_IDLE) begin
      if (start) begin
        if (is_md_op) begin
          hi_pend  <= res_hi;
          lo_pend  <= res_lo;
          div_zero <= md_op[1] & b_zero;
          cnt      <= cnt_load;
          state    <= S_RUN;
        end else if (md_op == OP_MTHI) begin
          HI <= A;
        end else if (md_op == OP_MTLO) begin
          LO <= A;
        end
      end
    end else begin
      if (cnt == 4'd1) begin
        if (!div_zero) begin
          HI <= hi_pend;
          LO <= lo_pend;
        end
        cnt   <= 4'd0;
        state <= S_IDLE;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign busy     = (state == S_RUN);
  assign md_stall = id_uses_md & (busy | (start & is_md_op));

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A, B;
  logic        id_uses_md;
  logic        busy;
  logic [31:0] HI, LO;
  logic        md_stall;

  int checks = 0;
  int errors = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op), .A(A), .B(B),
    .id_uses_md(id_uses_md), .busy(busy), .HI(HI), .LO(LO), .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  // Behavioural model: remaining busy cycles plus the architectural values.
  int          m_rem  = 0;
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;
  logic [31:0] p_hi   = 32'd0;
  logic [31:0] p_lo   = 32'd0;
  bit          p_skip = 1'b0;

  function automatic logic [63:0] model_result(input logic [2:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = sa * sb; return p; end
      3'd1: begin up = ua * ub; return up; end
      3'd2: begin
        if (b == 32'd0) return 64'd0;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return 64'd0;
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  <= 0;
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      p_hi   <= 32'd0;
      p_lo   <= 32'd0;
      p_skip <= 1'b0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1 && !p_skip) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
    end else if (start) begin
      if (md_op < 3'd4) begin
        {p_hi, p_lo} <= model_result(md_op, A, B);
        p_skip       <= (md_op >= 3'd2) && (B == 32'd0);
        m_rem        <= (md_op >= 3'd2) ? 10 : 5;
      end else if (md_op == 3'd4) begin
        m_hi <= A;
      end else if (md_op == 3'd5) begin
        m_lo <= A;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy", {31'd0, busy}, {31'd0, m_rem > 0});
      check("cyc_hi", HI, m_hi);
      check("cyc_lo", LO, m_lo);
      check("cyc_stall", {31'd0, md_stall},
            {31'd0, id_uses_md & ((m_rem > 0) | (start & (md_op < 3'd4)))});
    end
  end

  // Length of the most recent busy run, for literal latency checks.
  int run = 0;
  int last_run = 0;
  always @(negedge clk) begin
    if (busy) run <= run + 1;
    else if (run != 0) begin
      last_run <= run;
      run      <= 0;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles", n);
    end
  endtask

  task automatic op_and_check(input string name, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input int exp_run, input logic [31:0] exp_hi,
                              input logic [31:0] exp_lo);
    issue(op, a, b);
    wait_idle();
    @(negedge clk); #1;
    check({name, "_run"}, 32'(last_run), 32'(exp_run));
    check({name, "_hi"}, HI, exp_hi);
    check({name, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0; id_uses_md = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    rst_n  = 1'b1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);

    op_and_check("mult",  3'd0, 32'hFFFF_FFFF, 32'd2, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    op_and_check("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5,  32'h0000_0001, 32'hFFFF_FFFE);
    op_and_check("div",   3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    op_and_check("divu",  3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    op_and_check("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    // MTHI is single-cycle, then divide-by-zero leaves HI/LO alone.
    issue(3'd4, 32'h1234_5678, 32'd0);
    check("mthi_hi", HI, 32'h1234_5678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    op_and_check("divz", 3'd3, 32'd99, 32'd0, 10, 32'h1234_5678, 32'h8000_0000);

    // No-op encoding changes nothing.
    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    check("nop_busy", {31'd0, busy}, 32'd0);
    check("nop_hi", HI, 32'h1234_5678);

    // Stall through a MULT; MTLO and a second MULT during RUN are ignored.
    id_uses_md = 1'b1;
    start = 1'b1; md_op = 3'd0; A = 32'd3; B = 32'd5;
    #1;
    check("stall_start", {31'd0, md_stall}, 32'd1);
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd5; A = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    md_op = 3'd0; A = 32'd7; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    check("stall_run", {31'd0, md_stall}, 32'd1);
    check("run_lo_frozen", LO, 32'h8000_0000);
    wait_idle();
    check("stall_after", {31'd0, md_stall}, 32'd0);
    @(negedge clk); #1;
    check("ign_run", 32'(last_run), 32'd5);
    check("ign_lo", LO, 32'd15);
    check("ign_hi", HI, 32'd0);
    id_uses_md = 1'b0;

    // Asynchronous reset mid-operation.
    issue(3'd0, 32'd5, 32'd6);
    @(posedge clk); @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", HI, 32'd0);
    check("arst_lo", LO, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    op_and_check("post_rst", 3'd1, 32'd3, 32'd4, 5, 32'd0, 32'd12);

    // Back-to-back: second op issued in the cycle busy falls.
    issue(3'd0, 32'd2, 32'd3);
    wait_idle();
    check("b2b_lo1", LO, 32'd6);
    issue(3'd3, 32'd100, 32'd7);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_run1", 32'(last_run), 32'd5);
    wait_idle();
    @(negedge clk); #1;
    check("b2b_run2", 32'(last_run), 32'd10);
    check("b2b_lo2", LO, 32'd14);
    check("b2b_hi2", HI, 32'd2);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
